// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_queue
// Description : Instruction fetch front end: owns the fetch PC, issues one
//               read per cycle to a synchronous imem and buffers {data, pc}
//               in a small FIFO presented to decode with valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_queue #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic [DATA_WIDTH-1:0] inst_pc
);

    localparam int                    c_PTR_W   = $clog2(DEPTH);
    localparam logic [c_PTR_W+1:0]    c_DEPTH_W = (c_PTR_W + 2)'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] c_STEP    = DATA_WIDTH'(4);

    logic [DATA_WIDTH-1:0] r_fetch_pc;
    logic                  r_pending;
    logic [DATA_WIDTH-1:0] r_pending_pc;
    logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_pc   [DEPTH];
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W:0]      r_count;

    logic [c_PTR_W+1:0]    w_inflight;
    logic                  w_issue;
    logic                  w_push;
    logic                  w_valid;
    logic                  w_pop;
    logic                  w_unused_bits;

    // Credit counts the in-flight word too, so a push can never overflow;
    // a same-cycle pop is deliberately not counted as a free slot.
    assign w_inflight    = {1'b0, r_count} + {{(c_PTR_W + 1){1'b0}}, r_pending};
    assign w_issue       = rst_n && !redirect_valid && (w_inflight < c_DEPTH_W);
    assign w_push        = r_pending && !redirect_valid;
    assign w_valid       = rst_n && (r_count != '0);
    assign w_pop         = w_valid && inst_ready && !redirect_valid;
    assign w_unused_bits = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc   <= RESET_PC;
            r_pending    <= 1'b0;
            r_pending_pc <= RESET_PC;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= {redirect_pc[DATA_WIDTH-1:2], 2'b00};
            r_pending  <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_issue) begin
                r_fetch_pc   <= r_fetch_pc + c_STEP;
                r_pending    <= 1'b1;
                r_pending_pc <= r_fetch_pc;
            end else begin
                r_pending <= 1'b0;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; entries are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem_data[r_wr_ptr] <= imem_rdata;
            r_mem_pc[r_wr_ptr]   <= r_pending_pc;
        end
    end

    assign imem_req   = w_issue;
    assign imem_addr  = r_fetch_pc;
    assign inst_valid = w_valid;
    assign inst_data  = r_mem_data[r_rd_ptr];
    assign inst_pc    = r_mem_pc[r_rd_ptr];

endmodule
`default_nettype wire
